// File: rtl/spu_hazard_pkg.sv
// Shared constants and types for the SPU branch hazard controller.
//   NREG : number of architectural registers
//   AW   : register address width
//   LW   : pending-latency field width
//   SCW  : stall performance counter width
//   bc_state_t : branch control FSM state (RUN, HOLD, FLUSH)
package spu_hazard_pkg;

  localparam int NREG = 128;
  localparam int AW   = 7;
  localparam int LW   = 3;
  localparam int SCW  = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } bc_state_t;

endpackage

// File: rtl/spu_reg_scoreboard.sv
// Per-register pending-write latency scoreboard.
// Each entry holds the number of cycles until the pending result reaches the
// EX/MEM forwarding point; 0 means the register file holds the value.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   iss_valid, iss_wr   : instruction issued to EX that writes a register
//   iss_rt, iss_lat     : its destination and latency
//   ra, rb              : two read addresses
//   eff_a, eff_b        : effective remaining latency (with same-cycle bypass)
module spu_reg_scoreboard
  import spu_hazard_pkg::*;
#(
  parameter int NREG_P = NREG,
  parameter int AW_P   = AW,
  parameter int LW_P   = LW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic            iss_wr,
  input  logic [AW_P-1:0] iss_rt,
  input  logic [LW_P-1:0] iss_lat,
  input  logic [AW_P-1:0] ra,
  input  logic [AW_P-1:0] rb,
  output logic [LW_P-1:0] eff_a,
  output logic [LW_P-1:0] eff_b
);

  logic [LW_P-1:0] cnt [NREG_P];
  logic            iss_we;
  logic [LW_P-1:0] lat_next;

  assign iss_we = iss_valid & iss_wr;

  // The issuing cycle itself already sees iss_lat through the bypass, so the
  // stored value is one less: the entry always holds the remaining latency
  // as seen in the cycle it is read.
  assign lat_next = (iss_lat == '0) ? '0 : iss_lat - LW_P'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG_P; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG_P; i++) begin
        if (iss_we && (iss_rt == AW_P'(i))) begin
          cnt[i] <= lat_next;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LW_P'(1);
        end
      end
    end
  end

  assign eff_a = (iss_we && (iss_rt == ra)) ? iss_lat : cnt[ra];
  assign eff_b = (iss_we && (iss_rt == rb)) ? iss_lat : cnt[rb];

endmodule

// File: rtl/spu_branch_hazard_ctrl.sv
// Branch operand hazard control for the SPU decode stage.
// Decides per cycle whether a branch in ID reads its operands from the
// register file, the EX/MEM forwarding path, or must stall; flushes the
// wrong-path fetch for one cycle after a taken branch resolves.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   iss_valid/iss_wr/iss_rt/iss_lat: instruction entering EX
//   br_valid/br_use_a/br_use_b     : branch in ID and which operands it reads
//   br_ra/br_rb                    : branch source registers
//   br_taken                       : branch outcome, sampled on resolve
//   stall                          : hold IF/ID, bubble into EX
//   fwd_sel_a                      : 1 = operand A from EX/MEM
//   fwd_sel_b                      : 0 = operand B from EX/MEM (active-low)
//   flush                          : kill instruction in IF/ID
//   stall_cycles                   : saturating stall cycle count
//   state                          : FSM state, for observation
//
// Handshake: a branch is consumed (resolves) in any cycle where br_valid=1,
// stall=0 and the FSM is not in FLUSH; upstream keeps it stable otherwise.
module spu_branch_hazard_ctrl
  import spu_hazard_pkg::*;
#(
  parameter int NREG_P = NREG,
  parameter int AW_P   = AW,
  parameter int LW_P   = LW,
  parameter int SCW_P  = SCW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic             iss_wr,
  input  logic [AW_P-1:0]  iss_rt,
  input  logic [LW_P-1:0]  iss_lat,
  input  logic             br_valid,
  input  logic             br_use_a,
  input  logic             br_use_b,
  input  logic [AW_P-1:0]  br_ra,
  input  logic [AW_P-1:0]  br_rb,
  input  logic             br_taken,
  output logic             stall,
  output logic             fwd_sel_a,
  output logic             fwd_sel_b,
  output logic             flush,
  output logic [SCW_P-1:0] stall_cycles,
  output bc_state_t        state
);

  logic [LW_P-1:0] eff_a;
  logic [LW_P-1:0] eff_b;
  logic            active;
  logic            hz_a, hz_b, fw_a, fw_b;
  logic            resolve;
  bc_state_t       state_q, state_n;

  spu_reg_scoreboard #(
    .NREG_P (NREG_P),
    .AW_P   (AW_P),
    .LW_P   (LW_P)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_rt    (iss_rt),
    .iss_lat   (iss_lat),
    .ra        (br_ra),
    .rb        (br_rb),
    .eff_a     (eff_a),
    .eff_b     (eff_b)
  );

  // In FLUSH the branch in ID is the wrong-path instruction being killed.
  assign active = br_valid && (state_q != FLUSH);

  assign hz_a = br_use_a && (eff_a >= LW_P'(2));
  assign hz_b = br_use_b && (eff_b >= LW_P'(2));
  assign fw_a = br_use_a && (eff_a == LW_P'(1));
  assign fw_b = br_use_b && (eff_b == LW_P'(1));

  assign stall     = active && (hz_a || hz_b);
  assign fwd_sel_a = active && fw_a;
  assign fwd_sel_b = !(active && fw_b);
  assign resolve   = active && !stall;

  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN, HOLD: begin
        if (stall)        state_n = HOLD;
        else if (resolve) state_n = br_taken ? FLUSH : RUN;
      end
      FLUSH:   state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + SCW_P'(1);
    end
  end

  assign flush = (state_q == FLUSH);
  assign state = state_q;

endmodule

// File: tb/tb_spu_branch_hazard_ctrl.sv
module tb_spu_branch_hazard_ctrl;
  import spu_hazard_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            iss_valid, iss_wr;
  logic [AW-1:0]   iss_rt;
  logic [LW-1:0]   iss_lat;
  logic            br_valid, br_use_a, br_use_b;
  logic [AW-1:0]   br_ra, br_rb;
  logic            br_taken;
  logic            stall, fwd_sel_a, fwd_sel_b, flush;
  logic [SCW-1:0]  stall_cycles;
  bc_state_t       dut_state;

  spu_branch_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_wr       (iss_wr),
    .iss_rt       (iss_rt),
    .iss_lat      (iss_lat),
    .br_valid     (br_valid),
    .br_use_a     (br_use_a),
    .br_use_b     (br_use_b),
    .br_ra        (br_ra),
    .br_rb        (br_rb),
    .br_taken     (br_taken),
    .stall        (stall),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .flush        (flush),
    .stall_cycles (stall_cycles),
    .state        (dut_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each register remembers the absolute cycle at which its pending result
  // reaches the forwarding point; remaining latency is that minus "now".
  int ready_t [NREG];
  int now;
  bit m_flush;
  int m_sc;
  bit chk_en;

  // values observed in the last cycle, for directed checks
  logic obs_stall, obs_fa, obs_fb, obs_flush;
  logic [SCW-1:0] obs_sc;

  function automatic int eff_of(input logic [AW-1:0] r);
    int d;
    if (iss_valid && iss_wr && iss_rt == r) return int'(iss_lat);
    d = ready_t[r] - now;
    return (d > 0) ? d : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) ready_t[i] = 0;
    m_flush = 0;
    m_sc    = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    iss_valid = 0; iss_wr = 0; iss_rt = '0; iss_lat = '0;
    br_valid = 0; br_use_a = 0; br_use_b = 0; br_ra = '0; br_rb = '0;
    br_taken = 0; reset = 0;
  endtask

  task automatic set_iss(input int rt, input int lat);
    iss_valid = 1; iss_wr = 1; iss_rt = AW'(rt); iss_lat = LW'(lat);
  endtask

  task automatic set_br(input bit ua, input int ra, input bit ub, input int rb, input bit tk);
    br_valid = 1; br_use_a = ua; br_ra = AW'(ra); br_use_b = ub; br_rb = AW'(rb); br_taken = tk;
  endtask

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic cycle();
    int  ea, eb;
    bit  act, e_stall, e_fa, e_fb, resolve;
    #1;
    ea  = eff_of(br_ra);
    eb  = eff_of(br_rb);
    act = br_valid && !m_flush;
    e_stall = act && ((br_use_a && ea >= 2) || (br_use_b && eb >= 2));
    e_fa    = act && br_use_a && ea == 1;
    e_fb    = !(act && br_use_b && eb == 1);
    obs_stall = stall; obs_fa = fwd_sel_a; obs_fb = fwd_sel_b;
    obs_flush = flush; obs_sc = stall_cycles;
    if (chk_en) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("fwd_sel_a", 32'(fwd_sel_a), 32'(e_fa));
      check("fwd_sel_b", 32'(fwd_sel_b), 32'(e_fb));
      check("flush", 32'(flush), 32'(m_flush));
      check("stall_cycles", 32'(stall_cycles), 32'(m_sc));
    end
    resolve = act && !e_stall;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (e_stall && m_sc < 65535) m_sc++;
      m_flush = resolve && br_taken;
      if (iss_valid && iss_wr) ready_t[iss_rt] = now + int'(iss_lat);
    end
    now++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reset  = 1;
    chk_en = 0;
    now    = 0;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    chk_en = 1;
    idle();

    // reset state + empty scoreboard branch
    check("rst_state", 32'(dut_state), 32'(RUN));
    set_br(1, 5, 0, 0, 0);
    cycle();
    check("t1_stall", 32'(obs_stall), 0);
    check("t1_fa", 32'(obs_fa), 0);
    check("t1_fb", 32'(obs_fb), 1);
    check("t1_flush", 32'(obs_flush), 0);
    idle();

    // issue rt5 lat3, branch on A from next cycle
    do_reset();
    set_iss(5, 3);
    cycle();
    idle();
    set_br(1, 5, 0, 0, 0);
    cycle();
    check("t2_stall1", 32'(obs_stall), 1);
    cycle();
    check("t2_stall2", 32'(obs_stall), 0);
    check("t2_fa2", 32'(obs_fa), 1);
    check("t2_sc", 32'(obs_sc), 1);
    idle();
    cycle();

    // same-cycle bypass on B
    set_iss(9, 1);
    set_br(0, 0, 1, 9, 0);
    cycle();
    check("t3_stall", 32'(obs_stall), 0);
    check("t3_fb", 32'(obs_fb), 0);
    idle();

    // taken branch -> one-cycle flush, branch ignored during flush
    do_reset();
    set_br(1, 20, 0, 0, 1);
    cycle();
    check("t4_flush0", 32'(obs_flush), 0);
    set_iss(20, 5);
    set_br(1, 20, 0, 0, 1);
    cycle();
    check("t4_flush1", 32'(obs_flush), 1);
    check("t4_stall1", 32'(obs_stall), 0);
    idle();
    cycle();
    check("t4_flush2", 32'(obs_flush), 0);

    // hazard on both operands
    do_reset();
    set_iss(4, 2);
    cycle();
    idle();
    set_iss(3, 4);
    set_br(1, 3, 1, 4, 0);
    cycle();
    check("t5_stall_c1", 32'(obs_stall), 1);
    iss_valid = 0;
    cycle();
    check("t5_stall_c2", 32'(obs_stall), 1);
    cycle();
    check("t5_stall_c3", 32'(obs_stall), 1);
    cycle();
    check("t5_stall_c4", 32'(obs_stall), 0);
    check("t5_fa", 32'(obs_fa), 1);
    check("t5_fb", 32'(obs_fb), 1);
    idle();

    // reset in the middle of HOLD
    do_reset();
    set_iss(5, 7);
    cycle();
    idle();
    set_br(1, 5, 0, 0, 0);
    cycle();
    check("t6_hold", 32'(dut_state), 32'(HOLD));
    reset = 1;
    cycle();
    reset = 0;
    cycle();
    check("t6_stall", 32'(obs_stall), 0);
    check("t6_fa", 32'(obs_fa), 0);
    idle();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_wr    = ($urandom_range(0, 3) != 0);
      iss_rt    = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, NREG-1)) : AW'($urandom_range(0, 7));
      iss_lat   = LW'($urandom_range(0, 7));
      br_valid  = ($urandom_range(0, 2) != 0);
      br_use_a  = 1'($urandom_range(0, 1));
      br_use_b  = 1'($urandom_range(0, 1));
      br_ra     = AW'($urandom_range(0, 7));
      br_rb     = AW'($urandom_range(0, 7));
      br_taken  = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 79) == 0);
      cycle();
    end
    idle();

    // stall counter saturation
    do_reset();
    set_br(1, 7, 0, 0, 0);
    set_iss(7, 7);
    for (int n = 0; n < 70000; n++) cycle();
    idle();
    cycle();
    check("t7_sat", 32'(obs_sc), 32'd65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
